bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3, number of requesting masters on the serial bus.
REQ-002 Parameter GRANT_TIMEOUT_LEN, default 6, counter width in bits; granted master must claim the bus within 2^6 = 64 cycles.
REQ-003 Parameter TENURE_LEN, default 8, counter width in bits; maximum bus tenure is 2^8 = 256 cycles.
REQ-004 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: b_request  input  NUM_MASTERS  per-master bus request, level; bit i = master i.
REQ-007 Port: bus_util  input  1  high while the granted master is utilizing the bus.
REQ-008 Port: b_grant  output  NUM_MASTERS  one-hot grant, registered.
REQ-009 Port: grant_id  output  2  index of the current or last granted master.
REQ-010 Port: arbiter_cmd  output  1  one-cycle pulse commanding all slaves to abort and return to idle.
REQ-011 Port: timeout  output  1  one-cycle pulse on any grant or tenure timeout.
REQ-012 Port: state  output  4  current FSM state, zero-extended, for debug.

Function
REQ-013 FSM states shall be IDLE=0, GRANT=1, BUSY=2, RELEASE=3 and ABORT=4; encodings 5-15 shall go to IDLE on the next cycle.
REQ-014 Arbitration: round-robin from pointer rr_ptr; the winner is the first requesting index at or after rr_ptr, wrapping at NUM_MASTERS-1 to 0.
REQ-015 IDLE: if b_request is nonzero, latch the winner into grant_id, assert the one-hot b_grant on the next edge, clear the counter and enter GRANT; otherwise remain in IDLE with b_grant=0.
REQ-016 GRANT: b_grant shall be held and the counter incremented each cycle.
REQ-017 GRANT: bus_util=1 -> enter BUSY with the counter cleared.
REQ-018 GRANT: the granted request dropping with bus_util=0 -> enter RELEASE.
REQ-019 GRANT: the counter reaching 2^GRANT_TIMEOUT_LEN-1 with bus_util=0 -> enter ABORT.
REQ-020 BUSY: b_grant shall be held and the counter incremented each cycle.
REQ-021 BUSY: bus_util falling to 0 -> enter RELEASE.
REQ-022 BUSY: the counter reaching 2^TENURE_LEN-1 with bus_util=1 -> enter ABORT.
REQ-023 RELEASE: b_grant=0 for exactly one turnaround cycle, rr_ptr <= grant_id+1 (wrapping), then enter IDLE.
REQ-024 ABORT: b_grant=0, arbiter_cmd=1 and timeout=1 for exactly one cycle, rr_ptr <= grant_id+1 (wrapping), then enter IDLE.
REQ-025 Request-to-grant latency from IDLE shall be 1 cycle; the minimum gap between consecutive grants shall be 2 cycles (RELEASE/ABORT, then IDLE).
REQ-026 Requests arriving while not in IDLE shall be ignored until the FSM returns to IDLE; there shall be no preemption.
REQ-027 Simultaneous requests shall be resolved only by rr_ptr; a master shall not win twice in a row while another master requests.
REQ-028 At most one b_grant bit shall be high in any cycle.
REQ-029 bus_util=1 while in IDLE (foreign driver) shall block new grants until bus_util=0.
REQ-030 The counter shall never wrap; it shall saturate at its terminal value.

Reset
REQ-031 While rst=1: b_grant=0, grant_id=0, arbiter_cmd=0, timeout=0, state=IDLE, rr_ptr=0, counter=0.
REQ-032 Reset asserted mid-tenure shall drop b_grant immediately (asynchronously) without pulsing arbiter_cmd.
REQ-033 After rst deasserts, the first grant shall occur no earlier than the first rising edge of clk.

Verification
REQ-034 b_request=3'b110 from reset -> b_grant=3'b010 one cycle later, grant_id=1.
REQ-035 Master 1 raises bus_util 3 cycles after grant, holds it 10 cycles, then drops it -> b_grant=0 for one cycle, then b_grant=3'b100 while b_request=3'b110.
REQ-036 b_request=3'b001 with bus_util held at 0 -> after 64 cycles in GRANT, timeout and arbiter_cmd each pulse for 1 cycle, b_grant=0, then the grant is re-issued to master 0.
REQ-037 bus_util held at 1 for 300 cycles after grant -> ABORT at tenure cycle 256, arbiter_cmd pulses, rr_ptr advances.
REQ-038 b_request=3'b111 held constantly with 5-cycle tenures -> grant order 0,1,2,0,1,2.
REQ-039 rst pulsed during BUSY -> b_grant=0 within the same cycle, state=0, arbiter_cmd stays 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin serial bus arbiter with grant-claim and tenure timeouts
// that abort the bus and move the rotation pointer past the offending master.
module bus_arbiter #(
   parameter int NUM_MASTERS       = 3,
   parameter int GRANT_TIMEOUT_LEN = 6,
   parameter int TENURE_LEN        = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] b_request,
   input  logic                   bus_util,
   output logic [NUM_MASTERS-1:0] b_grant,
   output logic [1:0]             grant_id,
   output logic                   arbiter_cmd,
   output logic                   timeout,
   output logic [3:0]             state
);
   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] GRANT   = 4'd1;
   localparam logic [3:0] BUSY    = 4'd2;
   localparam logic [3:0] RELEASE = 4'd3;
   localparam logic [3:0] ABORT   = 4'd4;
   localparam int CW = GRANT_TIMEOUT_LEN > TENURE_LEN ? GRANT_TIMEOUT_LEN : TENURE_LEN;
   localparam logic [CW-1:0] GT_MAX = CW'((64'd1 << GRANT_TIMEOUT_LEN) - 64'd1);
   localparam logic [CW-1:0] TN_MAX = CW'((64'd1 << TENURE_LEN) - 64'd1);

   logic [3:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [1:0]             gid_q, gid_d, rr_q, rr_d, win, nxt_id;
   logic                   cmd_q, cmd_d, to_q, to_d;

   assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
   assign nxt_id  = gid_q == 2'(NUM_MASTERS-1) ? 2'd0 : gid_q + 2'd1;

   // Lowest requester overall is the wrap-around fallback; lowest at or above rr_q overrides it.
   always_comb begin
      win = '0;
      for (int i = NUM_MASTERS-1; i >= 0; i--) if (b_request[i]) win = 2'(i);
      for (int i = NUM_MASTERS-1; i >= 0; i--) if (b_request[i] && i >= int'(rr_q)) win = 2'(i);
   end

   always_comb begin
      state_d = IDLE;
      cnt_d   = cnt_inc;
      grant_d = '0;
      gid_d   = gid_q;
      rr_d    = rr_q;
      cmd_d   = 1'b0;
      to_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (|b_request && !bus_util) begin
               state_d = GRANT;
               gid_d   = win;
               grant_d = NUM_MASTERS'(1) << win;
            end
         end
         GRANT: begin
            grant_d = grant_q;
            if (bus_util) begin
               state_d = BUSY;
               cnt_d   = '0;
            end else if (!b_request[gid_q]) begin
               state_d = RELEASE;
               grant_d = '0;
            end else if (cnt_q == GT_MAX) begin
               state_d = ABORT;
               grant_d = '0;
               cmd_d   = 1'b1;
               to_d    = 1'b1;
            end else begin
               state_d = GRANT;
            end
         end
         BUSY: begin
            grant_d = grant_q;
            if (!bus_util) begin
               state_d = RELEASE;
               grant_d = '0;
            end else if (cnt_q == TN_MAX) begin
               state_d = ABORT;
               grant_d = '0;
               cmd_d   = 1'b1;
               to_d    = 1'b1;
            end else begin
               state_d = BUSY;
            end
         end
         RELEASE, ABORT: rr_d = nxt_id;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         gid_q   <= '0;
         rr_q    <= '0;
         cmd_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         rr_q    <= rr_d;
         cmd_q   <= cmd_d;
         to_q    <= to_d;
      end
   end

   assign b_grant     = grant_q;
   assign grant_id    = gid_q;
   assign arbiter_cmd = cmd_q;
   assign timeout     = to_q;
   assign state       = state_q;
endmodule
